// File: rtl/moving_sum.sv
// Sliding-window summer: running sum of the last WINDOW accepted samples, one registered result per
// accepted input. Optional synchronous clear port enabled by defining MOVING_SUM_CLEAR_EN.
module moving_sum #(
   parameter int unsigned WINDOW       = 8,
   parameter int unsigned INPUT_WIDTH  = 8,
   parameter int unsigned OUTPUT_WIDTH = INPUT_WIDTH + $clog2(WINDOW)
) (
   input  logic                    clk,
   input  logic                    rst,
`ifdef MOVING_SUM_CLEAR_EN
   input  logic                    clr,
`endif
   input  logic                    in_vld,
   input  logic [INPUT_WIDTH-1:0]  in_dat,
   output logic                    out_vld,
   output logic [OUTPUT_WIDTH-1:0] out_dat,
   output logic                    out_full
);

   localparam int unsigned PTR_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int unsigned CNT_W = $clog2(WINDOW + 1);
   localparam int unsigned SUM_W = OUTPUT_WIDTH + 1;

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WINDOW);

   logic [INPUT_WIDTH-1:0]  buf_q [WINDOW];
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [OUTPUT_WIDTH-1:0] sum_q, sum_d;
   logic                    vld_q;
   logic                    full_q;
   logic                    accept;
   logic [INPUT_WIDTH-1:0]  oldest;
   logic [SUM_W-1:0]        sum_ext;

`ifdef MOVING_SUM_CLEAR_EN
   assign accept = in_vld & ~clr;
`else
   assign accept = in_vld;
`endif

   always_comb begin
      // Entries are only trusted once the window has filled; before that they may be stale.
      oldest   = (count_q == CNT_FULL) ? buf_q[wr_ptr_q] : '0;
      sum_ext  = {1'b0, sum_q} + SUM_W'(in_dat) - SUM_W'(oldest);
      sum_d    = sum_ext[OUTPUT_WIDTH-1:0];
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      count_d  = (count_q == CNT_FULL) ? count_q : count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q    <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         vld_q    <= 1'b0;
`ifdef MOVING_SUM_CLEAR_EN
      end else if (clr) begin
         sum_q    <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         vld_q    <= 1'b0;
`endif
      end else begin
         vld_q <= accept;
         if (accept) begin
            sum_q    <= sum_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_FULL);
         end
      end
   end

   // No reset on the buffer; the fill count masks whatever it holds.
   always_ff @(posedge clk) begin
      if (accept && !rst) begin
         buf_q[wr_ptr_q] <= in_dat;
      end
   end

   assign out_vld  = vld_q;
   assign out_dat  = sum_q;
   assign out_full = full_q;

endmodule

// File: tb/tb_moving_sum.sv
// Randomized self-checking bench for moving_sum; three window sizes (8, 5, 1) run side by side
// against a queue-based reference model. Exercises clr when MOVING_SUM_CLEAR_EN is defined.
module tb_moving_sum;

   localparam int IW = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic        in_vld = 1'b0;
   logic [7:0]  in_dat = '0;

   logic        vld8, vld5, vld1;
   logic [10:0] dat8, dat5;
   logic [7:0]  dat1;
   logic        full8, full5, full1;

   int unsigned hist[$];
   int unsigned n_acc;
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          exp_vld;

   always #5 clk = ~clk;

   moving_sum #(.WINDOW(8), .INPUT_WIDTH(IW)) dut8 (
      .clk(clk), .rst(rst),
`ifdef MOVING_SUM_CLEAR_EN
      .clr(clr),
`endif
      .in_vld(in_vld), .in_dat(in_dat), .out_vld(vld8), .out_dat(dat8), .out_full(full8)
   );

   moving_sum #(.WINDOW(5), .INPUT_WIDTH(IW)) dut5 (
      .clk(clk), .rst(rst),
`ifdef MOVING_SUM_CLEAR_EN
      .clr(clr),
`endif
      .in_vld(in_vld), .in_dat(in_dat), .out_vld(vld5), .out_dat(dat5), .out_full(full5)
   );

   moving_sum #(.WINDOW(1), .INPUT_WIDTH(IW)) dut1 (
      .clk(clk), .rst(rst),
`ifdef MOVING_SUM_CLEAR_EN
      .clr(clr),
`endif
      .in_vld(in_vld), .in_dat(in_dat), .out_vld(vld1), .out_dat(dat1), .out_full(full1)
   );

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int unsigned win_sum(input int k);
      int unsigned s = 0;
      int m = (hist.size() < k) ? hist.size() : k;
      for (int i = 0; i < m; i++) s += hist[hist.size() - 1 - i];
      return s;
   endfunction

   // One clock of stimulus, then the model is advanced and all three DUTs are compared.
   task automatic apply(input bit r, input bit c, input bit v, input int unsigned d);
      @(negedge clk);
      rst    = r;
      clr    = c;
      in_vld = v;
      in_dat = 8'(d);
      @(posedge clk);
      #1;
`ifdef MOVING_SUM_CLEAR_EN
      if (r || c) begin
`else
      if (r) begin
`endif
         hist.delete();
         n_acc   = 0;
         exp_vld = 1'b0;
      end else if (v) begin
         hist.push_back(d & 32'hff);
         if (hist.size() > 8) void'(hist.pop_front());
         n_acc++;
         exp_vld = 1'b1;
      end else begin
         exp_vld = 1'b0;
      end
      check("vld8",  vld8,  exp_vld);
      check("dat8",  dat8,  win_sum(8));
      check("full8", full8, n_acc >= 8);
      check("vld5",  vld5,  exp_vld);
      check("dat5",  dat5,  win_sum(5));
      check("full5", full5, n_acc >= 5);
      check("vld1",  vld1,  exp_vld);
      check("dat1",  dat1,  win_sum(1));
      check("full1", full1, n_acc >= 1);
   endtask

   initial begin
      int unsigned t1_exp [8] = '{1, 3, 6, 10, 15, 21, 28, 36};
      n_acc   = 0;
      exp_vld = 1'b0;

      apply(1, 0, 0, 0);
      apply(1, 0, 1, 77);

      // Ramp 1..8, then wrap with 9 and 10.
      for (int i = 0; i < 8; i++) begin
         apply(0, 0, 1, i + 1);
         check("t1_dat", dat8, t1_exp[i]);
         check("t1_full", full8, i == 7);
      end
      apply(0, 0, 1, 9);
      check("t2_dat9", dat8, 44);
      apply(0, 0, 1, 10);
      check("t2_dat10", dat8, 52);

      // Full-scale input for 20 samples.
      apply(1, 0, 0, 0);
      for (int i = 0; i < 20; i++) apply(0, 0, 1, 255);
      check("t3_max8", dat8, 2040);
      check("t3_max5", dat5, 1275);

      // Gapped stream.
      apply(1, 0, 0, 0);
      apply(0, 0, 1, 5);
      check("t4_a", dat8, 5);
      apply(0, 0, 0, 200);
      apply(0, 0, 0, 201);
      check("t4_hold", dat8, 5);
      apply(0, 0, 1, 7);
      check("t4_b", dat8, 12);
      apply(0, 0, 0, 0);
      apply(0, 0, 1, 3);
      check("t4_c", dat8, 15);

      // Reset mid-stream beats a coincident valid.
      for (int i = 0; i < 12; i++) apply(0, 0, 1, $urandom_range(0, 255));
      apply(1, 0, 1, 99);
      check("t5_rst_dat", dat8, 0);
      check("t5_rst_full", full8, 0);
      apply(0, 0, 1, 4);
      check("t5_restart", dat8, 4);

`ifdef MOVING_SUM_CLEAR_EN
      for (int i = 0; i < 9; i++) apply(0, 0, 1, $urandom_range(1, 255));
      apply(0, 1, 1, 50);
      check("t6_clr_dat", dat8, 0);
      check("t6_clr_full", full8, 0);
      check("t6_clr_vld", vld8, 0);
      apply(0, 0, 1, 2);
      check("t6_a", dat8, 2);
      apply(0, 0, 1, 2);
      check("t6_b", dat8, 4);
      apply(1, 1, 1, 9);
`endif

      // Random traffic with occasional resets and clears.
      for (int i = 0; i < 600; i++) begin
         bit r = ($urandom_range(0, 99) < 2);
         bit c = ($urandom_range(0, 99) < 3);
`ifndef MOVING_SUM_CLEAR_EN
         c = 1'b0;
`endif
         apply(r, c, $urandom_range(0, 99) < 70, $urandom_range(0, 255));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
